// File: rtl/issuer_pkg.sv
// Shared definitions for the opcode issuer and the controller it feeds:
// FSM states, instruction field positions and the opcode set.
package issuer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        HALT
    } issuer_state_t;

    localparam logic [2:0] HALT_CODE_DEFAULT = 3'b111;

    // Instruction word layout: opcode in the top three bits, operand below.
    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 13;
    localparam int OPERAND_MSB = 12;
    localparam int OPERAND_LSB = 0;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_ADD    = 3'b011;
    localparam logic [2:0] OP_SUB    = 3'b100;
    localparam logic [2:0] OP_BRANCH = 3'b101;
    localparam logic [2:0] OP_JUMP   = 3'b110;
    localparam logic [2:0] OP_HALT   = 3'b111;

endpackage

// File: rtl/issuer_pc.sv
// Program counter with clear, load and wrapping increment (priority in that order).
// pc_next is exposed so the fetch address can be registered alongside the PC.
module issuer_pc #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic [PC_W-1:0] load_value,
    input  logic            inc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (clear) begin
            pc_next = '0;
        end else if (load) begin
            pc_next = load_value;
        end else if (inc) begin
            pc_next = pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/opcode_issuer.sv
// Fetches instruction words from program memory and issues their opcode and
// operand to a controller over a valid/ready handshake, one issue per three cycles.
module opcode_issuer
    import issuer_pkg::*;
#(
    parameter int         PC_W      = 8,
    parameter logic [2:0] HALT_CODE = HALT_CODE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            mem_rd,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_rdata,
    output logic [2:0]      code,
    output logic [12:0]     operand,
    output logic            code_valid,
    input  logic            code_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic [15:0]     issue_count
);

    issuer_state_t   state;
    logic [PC_W-1:0] pc_next;
    logic            handshake;
    logic            redirect_ok;
    logic            start_ok;
    logic            pc_inc;

    // code_valid is only ever high in ISSUE, so it alone qualifies a handshake.
    assign handshake   = code_valid && code_ready;
    assign redirect_ok = redirect && (state == FETCH || state == WAIT || state == ISSUE);
    assign start_ok    = start && (state == IDLE || state == HALT);
    assign pc_inc      = handshake && (code != HALT_CODE) && !redirect_ok;

    issuer_pc #(
        .PC_W(PC_W)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .load      (redirect_ok),
        .load_value(redirect_pc),
        .inc       (pc_inc),
        .pc        (pc),
        .pc_next   (pc_next)
    );

    // A redirect always restarts the fetch at redirect_pc and wins over both
    // the increment and HALT entry; a read already in flight is simply not latched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            code        <= '0;
            operand     <= '0;
            code_valid  <= 1'b0;
            halted      <= 1'b0;
            issue_count <= '0;
        end else begin
            if (handshake && issue_count != 16'hFFFF) begin
                issue_count <= issue_count + 16'd1;
            end

            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state    <= FETCH;
                        mem_rd   <= 1'b1;
                        mem_addr <= pc_next;
                        halted   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= pc_next;
                    end else begin
                        mem_rd <= 1'b0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        state    <= FETCH;
                        mem_rd   <= 1'b1;
                        mem_addr <= pc_next;
                    end else begin
                        code       <= mem_rdata[OPCODE_MSB:OPCODE_LSB];
                        operand    <= mem_rdata[OPERAND_MSB:OPERAND_LSB];
                        code_valid <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (redirect) begin
                        state      <= FETCH;
                        code_valid <= 1'b0;
                        mem_rd     <= 1'b1;
                        mem_addr   <= pc_next;
                    end else if (code_ready) begin
                        code_valid <= 1'b0;
                        if (code == HALT_CODE) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            mem_rd   <= 1'b1;
                            mem_addr <= pc_next;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_rd     <= 1'b0;
                    code_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
